// File: rtl/subcore_dispatcher.sv
// subcore_dispatcher
//   Queues fork requests from the main core in a circular FIFO and hands
//   them, one per cycle, to the lowest-index idle subcore.  A join barrier
//   blocks new forks until every queued and in-flight task has finished.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   fork_valid/pc      fork offer from the main core, fork_ready = accept
//   join_req           one-cycle join request, join_done one-cycle completion
//   exec_requested     per-subcore start pulse, requested_pc per-subcore start PC
//   subcore_ended      per-subcore completion pulse
//   busy_mask          per-subcore busy flags
//   pending_count      queued, not yet dispatched requests
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_RUN       | normal operation, forks accepted and dispatched
// ST_JOIN_WAIT | forks blocked, queue drains until all subcores are idle
// ST_JOIN_DONE | join_done high for this one cycle, then back to ST_RUN
module subcore_dispatcher #(
   parameter int NUM_SUB    = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               fork_valid,
   input  logic [31:0]                        fork_pc,
   output logic                               fork_ready,
   input  logic                               join_req,
   output logic                               join_done,
   output logic [NUM_SUB-1:0]                 exec_requested,
   output logic [NUM_SUB*32-1:0]              requested_pc,
   input  logic [NUM_SUB-1:0]                 subcore_ended,
   output logic [NUM_SUB-1:0]                 busy_mask,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    pending_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_JOIN_WAIT = 2'd1,
      ST_JOIN_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          mem_q [FIFO_DEPTH];
   logic [31:0]          mem_d [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [NUM_SUB-1:0]   busy_q, busy_d;
   logic [NUM_SUB-1:0]   exec_q, exec_d;
   logic [31:0]          pc_q [NUM_SUB];
   logic [31:0]          pc_d [NUM_SUB];
   logic                 join_done_q, join_done_d;

   logic                 push;
   logic                 pop;
   logic [SW-1:0]        sel_idx;
   logic [NUM_SUB-1:0]   sel_oh;

   // Readiness looks only at registered occupancy, so a pop in the same
   // cycle never opens a slot early in a full queue.
   assign fork_ready = (state_q == ST_RUN) && (count_q < FULL_CNT);
   assign push       = fork_valid && fork_ready;

   // Descending scan: the last idle subcore written wins, i.e. the lowest.
   always_comb begin
      pop     = 1'b0;
      sel_idx = '0;
      sel_oh  = '0;
      if (count_q != '0) begin
         for (int i = NUM_SUB - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
               pop     = 1'b1;
               sel_idx = SW'(i);
            end
         end
      end
      if (pop) sel_oh[sel_idx] = 1'b1;
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = fork_pc;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Ends on idle subcores fall out of the mask naturally; the newly
   // dispatched subcore is never one that is ending (it was idle).
   always_comb begin
      busy_d = (busy_q & ~subcore_ended) | sel_oh;
      exec_d = sel_oh;
      pc_d   = pc_q;
      if (pop) pc_d[sel_idx] = mem_q[rd_ptr_q];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:       if (join_req) state_d = ST_JOIN_WAIT;
         ST_JOIN_WAIT: if ((count_q == '0) && (busy_q == '0)) state_d = ST_JOIN_DONE;
         ST_JOIN_DONE: state_d = ST_RUN;
         default:      state_d = ST_RUN;
      endcase
      join_done_d = (state_d == ST_JOIN_DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_RUN;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         busy_q      <= '0;
         exec_q      <= '0;
         pc_q        <= '{default: '0};
         join_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         exec_q      <= exec_d;
         pc_q        <= pc_d;
         join_done_q <= join_done_d;
      end
   end

   for (genvar g = 0; g < NUM_SUB; g++) begin : g_pc_out
      assign requested_pc[32*g +: 32] = pc_q[g];
   end

   assign exec_requested = exec_q;
   assign busy_mask      = busy_q;
   assign pending_count  = count_q;
   assign join_done      = join_done_q;

endmodule

// File: doc/subcore_dispatcher.md
SUBCORE_DISPATCHER -- requirements
Module: subcore_dispatcher

Interface
REQ-001 Parameter NUM_SUB, default 4: number of subcores served; legal values 1..8.
REQ-002 Parameter FIFO_DEPTH, default 8: fork-request queue depth; power of two, 2..32.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low; the block has one clock, and asynchronous active-low reset is fixed.
REQ-005 fork_valid  input  1  main core offers a fork request this cycle.
REQ-006 fork_pc  input  32  start PC of the forked task.
REQ-007 fork_ready  output  1  request accepted when fork_valid and fork_ready are both 1.
REQ-008 join_req  input  1  one-cycle pulse: main core requests a join barrier.
REQ-009 join_done  output  1  one-cycle pulse: join barrier satisfied.
REQ-010 exec_requested  output  NUM_SUB  per-subcore one-cycle start pulse.
REQ-011 requested_pc  output  NUM_SUB*32  per-subcore start PC; slice i is bits 32*i+31:32*i.
REQ-012 subcore_ended  input  NUM_SUB  per-subcore one-cycle completion pulse.
REQ-013 busy_mask  output  NUM_SUB  registered per-subcore busy flags.
REQ-014 pending_count  output  $clog2(FIFO_DEPTH+1)  number of queued, undispatched requests.

Function
REQ-015 The queue SHALL be a circular FIFO with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-016 fork_ready SHALL be 1 only when the state is RUN and the registered pending_count is below FIFO_DEPTH; a same-cycle pop SHALL NOT make a full queue ready.
REQ-017 An accepted request SHALL be written to the tail; with a simultaneous pop, pending_count SHALL be unchanged.
REQ-018 Each cycle, if pending_count>0 and some busy_mask bit is 0, the block SHALL pop the head to the lowest-index idle subcore i.
REQ-019 On that dispatch, the block SHALL register exec_requested[i]=1 for exactly one cycle, load requested_pc slice i with the head PC, and set busy_mask[i].
REQ-020 The block SHALL dispatch at most one request per cycle.
REQ-021 A request accepted at edge N SHALL be dispatched no earlier than edge N+1; there is no FIFO bypass.
REQ-022 requested_pc slice i SHALL hold its value until the next dispatch to subcore i.
REQ-023 subcore_ended[i]=1 while busy_mask[i]=1 SHALL clear busy_mask[i] at the next edge; subcore i is dispatchable from the following cycle.
REQ-024 subcore_ended[i]=1 while busy_mask[i]=0 SHALL be ignored.
REQ-025 An end and a dispatch on different subcores in the same cycle SHALL both take effect.
REQ-026 The FSM states SHALL be RUN, JOIN_WAIT and JOIN_DONE.
REQ-027 RUN -> JOIN_WAIT on join_req; a join_req outside RUN SHALL be ignored.
REQ-028 In JOIN_WAIT, fork_ready SHALL be 0 and dispatch SHALL continue.
REQ-029 JOIN_WAIT -> JOIN_DONE when pending_count==0 and busy_mask==0, evaluated on registered values.
REQ-030 In JOIN_DONE, join_done SHALL be 1 for one cycle, then the FSM SHALL return to RUN.
REQ-031 join_req together with fork_valid in RUN SHALL accept the fork, and the join SHALL wait for that fork to complete.

Reset
REQ-032 While rstn=0, all state SHALL clear immediately: FIFO empty, pointers 0, FSM RUN.
REQ-033 While rstn=0, exec_requested, requested_pc, busy_mask, pending_count and join_done SHALL be 0, and fork_ready SHALL be 1.
REQ-034 A reset mid-operation SHALL discard all queued and in-flight requests without emitting exec_requested pulses.

Verification
REQ-035 NUM_SUB=4, depth 8; fork PCs 0x100,0x200,0x300 in three consecutive cycles -> exec_requested pulses 0001,0010,0100 on the next three cycles; requested_pc slices 0x100,0x200,0x300.
REQ-036 All 4 subcores busy; push 8 forks -> pending_count=8, fork_ready=0; pulse subcore_ended[2] -> busy_mask[2] clears next edge, then dispatch to subcore 2, pending_count=7, fork_ready=1.
REQ-037 Full queue with fork_valid held and a pop in the same cycle -> no accept that cycle; accept on the following cycle; pending_count never exceeds 8.
REQ-038 Two forks outstanding, then join_req -> fork_ready=0 until join_done; join_done pulses exactly once, on the cycle after both subcore_ended pulses have cleared busy_mask.
REQ-039 rstn asserted with 3 queued and 2 busy -> immediately all outputs 0 and fork_ready=1; no exec_requested after release until a new fork arrives.
REQ-040 subcore_ended[1] pulsed while subcore 1 is idle -> no state change; push more than FIFO_DEPTH requests in total -> pointer wrap preserves FIFO order.
